// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete combinationally; misses write back a dirty victim, then refill the 128-bit line.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// S_COMPARE    | idle / tag lookup; hits complete in the same cycle
// S_WRITE_BACK | dirty victim line being written to memory
// S_ALLOCATE   | requested line being read from memory into the set
module dcache_ctrl #(
   parameter int NUM_SETS = 16,
   parameter int LINE_W   = 128
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req_valid,
   input  logic              cpu_req_rw,
   input  logic              cpu_req_byte,
   input  logic [31:0]       cpu_req_addr,
   input  logic [31:0]       cpu_req_wdata,
   output logic [31:0]       cpu_res_data,
   output logic              cpu_res_ready,
   output logic              mem_req_valid,
   output logic              mem_req_rw,
   output logic [31:0]       mem_req_addr,
   output logic [LINE_W-1:0] mem_req_data,
   input  logic              mem_data_ready,
   input  logic [LINE_W-1:0] mem_data_data,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = 32 - 4 - IDX_W;

   typedef enum logic [1:0] {
      S_COMPARE    = 2'd0,
      S_WRITE_BACK = 2'd1,
      S_ALLOCATE   = 2'd2
   } state_t;

   state_t              state_q;
   logic [NUM_SETS-1:0] valid_q;
   logic [NUM_SETS-1:0] dirty_q;
   logic [TAG_W-1:0]    tag_q  [NUM_SETS];
   logic [LINE_W-1:0]   line_q [NUM_SETS];

   logic [IDX_W-1:0]    idx;
   logic [TAG_W-1:0]    req_tag;
   logic [6:0]          word_pos;
   logic [6:0]          byte_pos;
   logic [LINE_W-1:0]   cur_line;
   logic [LINE_W-1:0]   merged_line;
   logic                hit;

   assign idx      = cpu_req_addr[4 +: IDX_W];
   assign req_tag  = cpu_req_addr[31 -: TAG_W];
   assign word_pos = {cpu_req_addr[3:2], 5'd0};
   assign byte_pos = {cpu_req_addr[3:0], 3'd0};
   assign cur_line = line_q[idx];
   assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);

   assign cpu_res_ready = (state_q == S_COMPARE) && cpu_req_valid && hit;

   always_comb begin
      cpu_res_data = '0;
      if (cpu_res_ready) begin
         cpu_res_data = cpu_req_byte ? {24'd0, cur_line[byte_pos +: 8]}
                                     : cur_line[word_pos +: 32];
      end
   end

   always_comb begin
      merged_line = cur_line;
      if (cpu_req_byte) merged_line[byte_pos +: 8]  = cpu_req_wdata[7:0];
      else              merged_line[word_pos +: 32] = cpu_req_wdata;
   end

   // Control state, status bits, counters and the registered memory request.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= S_COMPARE;
         valid_q       <= '0;
         dirty_q       <= '0;
         mem_req_valid <= 1'b0;
         mem_req_rw    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_data  <= '0;
         hit_count     <= '0;
         miss_count    <= '0;
      end else begin
         case (state_q)
            S_COMPARE: begin
               if (cpu_req_valid) begin
                  if (hit) begin
                     hit_count <= hit_count + 32'd1;
                     if (cpu_req_rw) dirty_q[idx] <= 1'b1;
                  end else begin
                     miss_count    <= miss_count + 32'd1;
                     mem_req_valid <= 1'b1;
                     if (valid_q[idx] && dirty_q[idx]) begin
                        state_q      <= S_WRITE_BACK;
                        mem_req_rw   <= 1'b1;
                        mem_req_addr <= {tag_q[idx], idx, 4'd0};
                        mem_req_data <= cur_line;
                     end else begin
                        state_q      <= S_ALLOCATE;
                        mem_req_rw   <= 1'b0;
                        mem_req_addr <= {req_tag, idx, 4'd0};
                     end
                  end
               end
            end
            S_WRITE_BACK: begin
               if (mem_data_ready) begin
                  dirty_q[idx] <= 1'b0;
                  state_q      <= S_ALLOCATE;
                  mem_req_rw   <= 1'b0;
                  mem_req_addr <= {req_tag, idx, 4'd0};
               end
            end
            S_ALLOCATE: begin
               if (mem_data_ready) begin
                  valid_q[idx]  <= 1'b1;
                  dirty_q[idx]  <= 1'b0;
                  state_q       <= S_COMPARE;
                  mem_req_valid <= 1'b0;
               end
            end
            default: state_q <= S_COMPARE;
         endcase
      end
   end

   // Tag and data arrays; writes are gated by the reset-cleared state, so an
   // abandoned refill never lands in the array.
   always_ff @(posedge clock) begin
      if (cpu_res_ready && cpu_req_rw) begin
         line_q[idx] <= merged_line;
      end
      if ((state_q == S_ALLOCATE) && mem_data_ready) begin
         line_q[idx] <= mem_data_data;
         tag_q[idx]  <= req_tag;
      end
   end

   a_req_stable: assert property (@(posedge clock) disable iff (reset)
      (state_q != S_COMPARE) |-> ($stable(cpu_req_valid) && $stable(cpu_req_rw) &&
                                  $stable(cpu_req_byte) && $stable(cpu_req_addr) &&
                                  $stable(cpu_req_wdata)))
      else $error("core request changed while a miss was outstanding");

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: flat-memory reference model, randomized traffic,
// and a 6-cycle-response main memory model.
module tb_dcache_ctrl;
   logic         clock = 1'b0;
   logic         reset;
   logic         cpu_req_valid, cpu_req_rw, cpu_req_byte;
   logic [31:0]  cpu_req_addr, cpu_req_wdata, cpu_res_data;
   logic         cpu_res_ready;
   logic         mem_req_valid, mem_req_rw;
   logic [31:0]  mem_req_addr;
   logic [127:0] mem_req_data;
   logic         mem_data_ready;
   logic [127:0] mem_data_data;
   logic [31:0]  hit_count, miss_count;

   dcache_ctrl #(.NUM_SETS(16), .LINE_W(128)) dut (
      .clock(clock), .reset(reset),
      .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw), .cpu_req_byte(cpu_req_byte),
      .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
      .cpu_res_data(cpu_res_data), .cpu_res_ready(cpu_res_ready),
      .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
      .mem_req_data(mem_req_data), .mem_data_ready(mem_data_ready), .mem_data_data(mem_data_data),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clock = ~clock;

   typedef struct { bit rw; logic [31:0] addr; logic [127:0] data; } mem_txn_t;
   typedef struct { bit is_load; logic [31:0] data; } res_t;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: architectural memory (what loads must return), backing memory
   // (what DRAM holds), and per-set residency used only to predict latency/traffic.
   logic [127:0] arch    [logic [27:0]];
   logic [127:0] backing [logic [27:0]];
   bit           m_valid [16];
   bit           m_dirty [16];
   logic [23:0]  m_tag   [16];
   logic [31:0]  m_hits, m_misses;
   mem_txn_t     mem_exp[$];
   res_t         res_exp[$];

   function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endfunction

   function automatic void fail_now(string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s", nm);
   endfunction

   function automatic logic [127:0] dflt(logic [27:0] la);
      logic [31:0] a;
      a = {4'd0, la};
      return {a ^ 32'hA5A5_0000, ~a, a + 32'h0100_0000, {a[15:0], a[31:16]}};
   endfunction

   function automatic logic [127:0] arch_get(logic [27:0] la);
      return arch.exists(la) ? arch[la] : dflt(la);
   endfunction

   function automatic logic [127:0] back_get(logic [27:0] la);
      return backing.exists(la) ? backing[la] : dflt(la);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 0;
         m_dirty[i] = 0;
         m_tag[i]   = '0;
      end
      m_hits   = '0;
      m_misses = '0;
      mem_exp.delete();
      res_exp.delete();
      arch = backing;
   endfunction

   // Issue one request, hold it until completion, check latency and counters.
   task automatic do_req(input bit rw, input bit byt, input logic [31:0] addr,
                         input logic [31:0] wdata);
      logic [3:0]   set;
      logic [23:0]  tag;
      logic [127:0] line, tmp, mask;
      int           sh, lat, c;
      mem_txn_t     t;
      res_t         r;
      set = addr[7:4];
      tag = addr[31:8];
      if (m_valid[set] && m_tag[set] == tag) begin
         lat = 0;
      end else begin
         m_misses = m_misses + 1;
         if (m_valid[set] && m_dirty[set]) begin
            lat    = 15;
            t.rw   = 1;
            t.addr = {m_tag[set], set, 4'd0};
            t.data = arch_get({m_tag[set], set});
            mem_exp.push_back(t);
         end else begin
            lat = 8;
         end
         t.rw   = 0;
         t.addr = {addr[31:4], 4'd0};
         t.data = '0;
         mem_exp.push_back(t);
         m_valid[set] = 1;
         m_dirty[set] = 0;
         m_tag[set]   = tag;
      end
      m_hits = m_hits + 1;
      line   = arch_get(addr[31:4]);
      sh     = int'(addr[3:0]) * 8;
      if (rw) begin
         mask = byt ? 128'hFF : 128'hFFFF_FFFF;
         line = (line & ~(mask << sh)) | ((128'(wdata) & mask) << sh);
         arch[addr[31:4]] = line;
         m_dirty[set] = 1;
         r.is_load = 0;
         r.data    = '0;
      end else begin
         tmp       = line >> sh;
         r.is_load = 1;
         r.data    = byt ? {24'd0, tmp[7:0]} : tmp[31:0];
      end
      res_exp.push_back(r);

      cpu_req_valid = 1'b1;
      cpu_req_rw    = rw;
      cpu_req_byte  = byt;
      cpu_req_addr  = addr;
      cpu_req_wdata = wdata;
      for (c = 0; c <= 40; c++) begin
         @(negedge clock);
         if (cpu_res_ready) break;
      end
      chk("latency", 128'(c), 128'(lat));
      @(posedge clock);
      #1;
      chk("hit_count", 128'(hit_count), 128'(m_hits));
      chk("miss_count", 128'(miss_count), 128'(m_misses));
   endtask

   task automatic idle(input int n);
      cpu_req_valid = 1'b0;
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Monitor: every completion pops one expected response.
   always @(negedge clock) begin
      if (!reset && cpu_res_ready) begin
         if (res_exp.size() == 0) begin
            fail_now("unexpected cpu_res_ready");
         end else begin
            res_t e;
            e = res_exp.pop_front();
            if (e.is_load) chk("load_data", 128'(cpu_res_data), 128'(e.data));
         end
      end
   end

   // Main memory: request seen in cycle N is answered with a one-cycle ready in N+6.
   initial begin
      bit          busy;
      int          cnt;
      bit          cur_rw;
      logic [31:0] cur_addr;
      mem_txn_t    e;
      busy = 0;
      cnt  = 0;
      cur_rw = 0;
      cur_addr = '0;
      mem_data_ready = 1'b0;
      mem_data_data  = '0;
      forever begin
         @(posedge clock);
         #2;
         if (reset) begin
            busy = 0;
            mem_data_ready = 1'b0;
            continue;
         end
         if (mem_data_ready) begin
            mem_data_ready = 1'b0;
            busy = 0;
         end else if (busy) begin
            cnt++;
            if (cnt == 7) begin
               chk("mem_req_held", {mem_req_valid, mem_req_rw, mem_req_addr},
                   {1'b1, cur_rw, cur_addr});
               if (cur_rw) begin
                  backing[cur_addr[31:4]] = mem_req_data;
                  mem_data_data = '0;
               end else begin
                  mem_data_data = back_get(cur_addr[31:4]);
               end
               mem_data_ready = 1'b1;
            end
         end
         if (!busy && mem_req_valid) begin
            busy     = 1;
            cnt      = 1;
            cur_rw   = mem_req_rw;
            cur_addr = mem_req_addr;
            if (mem_exp.size() == 0) begin
               fail_now("unexpected memory request");
            end else begin
               e = mem_exp.pop_front();
               chk("mem_req_rw", 128'(mem_req_rw), 128'(e.rw));
               chk("mem_req_addr", 128'(mem_req_addr), 128'(e.addr));
               if (e.rw) chk("writeback_data", mem_req_data, e.data);
            end
         end
      end
   end

   initial begin
      #500000;
      fail_now("global timeout");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] h0, a, d;
      logic [3:0]  s;
      bit          rw, byt;
      reset = 1'b1;
      cpu_req_valid = 1'b0;
      cpu_req_rw = 1'b0;
      cpu_req_byte = 1'b0;
      cpu_req_addr = '0;
      cpu_req_wdata = '0;
      backing[28'h4] = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      chk("rst mem_req_valid", 128'(mem_req_valid), 128'(0));
      chk("rst mem_req_rw", 128'(mem_req_rw), 128'(0));
      chk("rst mem_req_addr", 128'(mem_req_addr), 128'(0));
      chk("rst mem_req_data", mem_req_data, 128'(0));
      chk("rst cpu_res_ready", 128'(cpu_res_ready), 128'(0));
      chk("rst cpu_res_data", 128'(cpu_res_data), 128'(0));
      chk("rst hit_count", 128'(hit_count), 128'(0));
      chk("rst miss_count", 128'(miss_count), 128'(0));
      reset = 1'b0;
      @(posedge clock);
      #1;

      // Directed: refill, hit, byte store/load, dirty eviction, reload from memory.
      do_req(0, 0, 32'h0000_0040, '0);
      do_req(0, 0, 32'h0000_0044, '0);
      do_req(1, 1, 32'h0000_0047, 32'h0000_005A);
      do_req(0, 1, 32'h0000_0047, '0);
      do_req(0, 0, 32'h0000_0044, '0);
      idle(2);
      do_req(0, 0, 32'h0000_0140, '0);
      idle(1);
      do_req(0, 0, 32'h0000_0044, '0);
      chk("reload_value", arch_get(28'h4) >> 32, 128'h0000_0000_DDDD_DDDD_CCCC_CCCC_5ABB_BBBB);
      idle(1);

      // Back-to-back hits on four sets with valid held high.
      do_req(0, 0, 32'h0000_0000, '0);
      do_req(0, 0, 32'h0000_0010, '0);
      do_req(0, 0, 32'h0000_0020, '0);
      do_req(0, 0, 32'h0000_0030, '0);
      idle(1);
      h0 = hit_count;
      do_req(0, 0, 32'h0000_0004, '0);
      do_req(1, 0, 32'h0000_0018, 32'h1234_5678);
      do_req(0, 1, 32'h0000_002D, '0);
      do_req(0, 0, 32'h0000_0030, '0);
      chk("b2b_hit_delta", 128'(hit_count - h0), 128'(4));
      idle(1);

      // Reset while the refill is outstanding.
      begin
         mem_txn_t t;
         t.rw = 0;
         t.addr = 32'h0000_0290;
         t.data = '0;
         mem_exp.push_back(t);
      end
      cpu_req_valid = 1'b1;
      cpu_req_rw = 1'b0;
      cpu_req_byte = 1'b0;
      cpu_req_addr = 32'h0000_0290;
      repeat (3) @(negedge clock);
      chk("alloc_pending", {126'd0, mem_req_valid, mem_req_rw}, 128'b10);
      #1;
      reset = 1'b1;
      cpu_req_valid = 1'b0;
      #1;
      chk("abort mem_req_valid", 128'(mem_req_valid), 128'(0));
      chk("abort hit_count", 128'(hit_count), 128'(0));
      chk("abort miss_count", 128'(miss_count), 128'(0));
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;
      do_req(0, 0, 32'h0000_0290, '0);
      do_req(0, 0, 32'h0000_0044, '0);
      idle(1);

      // Randomized traffic over a small tag pool so hits, conflicts and evictions mix.
      for (int i = 0; i < 300; i++) begin
         s   = 4'($urandom_range(0, 15));
         rw  = 1'($urandom_range(0, 1));
         byt = 1'($urandom_range(0, 1));
         a   = {22'd0, 2'($urandom_range(0, 3)), s, 4'($urandom_range(0, 15))};
         if (!byt) a[1:0] = 2'b00;
         d   = $urandom;
         do_req(rw, byt, a, d);
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
      end
      idle(3);
      chk("res_queue_drained", 128'(res_exp.size()), 128'(0));
      chk("mem_queue_drained", 128'(mem_exp.size()), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
